pipe_stage_skid: RTL
====================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_WIDTH, default 64: payload width in bits.
REQ-002 Parameter THREAD_BITS, default 2: thread-id width in bits.
REQ-003 Port clk  input  1  rising-edge clock; the block SHALL use this single clock only.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  upstream beat present.
REQ-006 Port in_ready  output  1  block accepts a beat this cycle; SHALL come straight from a register.
REQ-007 Port in_data  input  DATA_WIDTH  upstream payload.
REQ-008 Port in_thread  input  THREAD_BITS  thread id of the upstream beat.
REQ-009 Port out_valid  output  1  head entry present.
REQ-010 Port out_ready  input  1  downstream accepts the head entry.
REQ-011 Port out_data  output  DATA_WIDTH  head payload.
REQ-012 Port out_thread  output  THREAD_BITS  head thread id.
REQ-013 Port flush_en  input  1  drop all entries of thread flush_thread.
REQ-014 Port flush_thread  input  THREAD_BITS  thread selected for flush.
REQ-015 Port flush_all  input  1  drop every entry regardless of thread.
REQ-016 Port occupancy  output  2  number of valid entries held, 0 to 2.

Function
REQ-017 Storage SHALL be two entries, a head register driving out_* and a skid register, each holding valid, data and thread.
REQ-018 Accept SHALL occur when in_valid and in_ready are both 1; complete SHALL occur when out_valid and out_ready are both 1.
REQ-019 in_ready SHALL be the registered value of NOT skid_valid for the next cycle.
REQ-020 Order SHALL be FIFO: a beat accepted into an empty block SHALL appear on out_* on the next cycle, giving 1-cycle latency.
REQ-021 If the head is empty, or is being completed this cycle, and the skid is empty, an accepted beat SHALL load the head.
REQ-022 If the head is held and not completed, an accepted beat SHALL load the skid.
REQ-023 When the head is completed and the skid is valid, the skid SHALL move to the head in the same edge; any accepted beat SHALL then load the skid.
REQ-024 Under full throughput (in_valid=out_ready=1 every cycle), the block SHALL accept and complete one beat per cycle with no bubbles.
REQ-025 When flush_en=1, every stored entry whose thread equals flush_thread SHALL be invalidated at the edge, and a beat accepted that cycle with a matching thread SHALL be discarded.
REQ-026 A discarded beat SHALL still count as accepted, and flush SHALL NOT change in_ready for the current cycle.
REQ-027 flush_all=1 SHALL invalidate both entries and discard any beat accepted that cycle; flush_all SHALL take priority over flush_en.
REQ-028 A head completed in the same cycle as its flush SHALL count as delivered, and the flush SHALL act only on the remaining entries.
REQ-029 If a flush removes the head but not a valid skid entry, the skid entry SHALL move to the head at that edge.
REQ-030 After a flush, the surviving entries and any surviving accepted beat SHALL keep FIFO order.
REQ-031 occupancy SHALL equal head_valid plus skid_valid as registered values.
REQ-032 out_data and out_thread SHALL hold their last values while out_valid=0, and SHALL NOT be relied on in that state.

Reset
REQ-033 While reset=1, at each clk edge both valids SHALL be cleared, data and thread registers SHALL be zeroed, in_ready SHALL be 1 and occupancy SHALL be 0.
REQ-034 Reset SHALL override handshakes and flushes in the same cycle, and any beat offered during reset SHALL be discarded.
REQ-035 Reset asserted mid-stream SHALL lose all held entries, and the first accept after release SHALL behave as in an empty block.

Structure
REQ-036 DATA_WIDTH and THREAD_BITS defaults SHALL live in the shared pipeline package, alongside a packed entry type {valid, thread, data}.
REQ-037 One sub-module, pipe_entry_reg, SHALL implement a single entry with load, clear and flush-match logic, and SHALL be instantiated twice.

Verification
REQ-038 Reset then stream in_data 0x10,0x11,0x12 with out_ready=1 -> out_data shows 0x10,0x11,0x12 on consecutive cycles, each one cycle after accept; occupancy stays 1.
REQ-039 out_ready=0, send 0xA (thread 1) then 0xB (thread 2) -> occupancy=2, in_ready=0; then out_ready=1 -> 0xA then 0xB delivered, in_ready returns to 1.
REQ-040 Head 0xA thread 1, skid 0xB thread 2, flush_en=1, flush_thread=1, out_ready=0 -> next cycle out_data=0xB, occupancy=1.
REQ-041 Block full, flush_all=1 while in_valid=1 with 0xC -> next cycle out_valid=0, occupancy=0, and 0xC never appears.
REQ-042 Head 0xA thread 3 completed in the same cycle as flush_en with flush_thread=3, skid 0xD thread 3 -> 0xA delivered once, 0xD dropped, occupancy=0.
REQ-043 Reset pulsed for one cycle with occupancy=2 -> next cycle occupancy=0 and in_ready=1; a new beat 0x5 appears on out_data one cycle after its accept.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid_pkg
// Shared pipeline package for the skid-buffered pipeline stage.
//   - Default payload and thread-id widths.
//   - Packed entry type {valid, thread, data} at the default widths.
//   - Source selectors for the head and skid entries.
//   - Small helper to count valid entries.
// -----------------------------------------------------------------------------
package pipe_stage_skid_pkg;

  localparam int DATA_WIDTH_DEF  = 64;
  localparam int THREAD_BITS_DEF = 2;

  // One stored beat at the default widths.
  typedef struct packed {
    logic                       valid;
    logic [THREAD_BITS_DEF-1:0] thread;
    logic [DATA_WIDTH_DEF-1:0]  data;
  } pipe_entry_t;

  // Where the head entry takes its next contents from.
  typedef enum logic [1:0] {
    HEAD_HOLD      = 2'd0,
    HEAD_FROM_SKID = 2'd1,
    HEAD_FROM_IN   = 2'd2,
    HEAD_EMPTY     = 2'd3
  } head_src_t;

  // Where the skid entry takes its next contents from.
  typedef enum logic [1:0] {
    SKID_HOLD    = 2'd0,
    SKID_FROM_IN = 2'd1,
    SKID_EMPTY   = 2'd2
  } skid_src_t;

  // Number of valid entries given the two valid bits.
  function automatic logic [1:0] count_valid(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// -----------------------------------------------------------------------------
// pipe_entry_reg
// A single storage entry (valid, thread, data) of the skid stage.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   load                : capture load_data/load_thread and become valid
//   load_data/thread    : contents to capture
//   clear               : invalidate the entry (data/thread are kept)
//   flush_en/thread/all : flush request, used to report a match
//   valid, data, thread : stored contents
//   flush_hit           : stored entry is valid and selected by the flush
// Priority at the edge: reset, then load, then clear, then hold.
// -----------------------------------------------------------------------------
module pipe_entry_reg
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int THREAD_BITS = THREAD_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [DATA_WIDTH-1:0]  load_data,
  input  logic [THREAD_BITS-1:0] load_thread,
  input  logic                   clear,
  input  logic                   flush_en,
  input  logic [THREAD_BITS-1:0] flush_thread,
  input  logic                   flush_all,
  output logic                   valid,
  output logic [DATA_WIDTH-1:0]  data,
  output logic [THREAD_BITS-1:0] thread,
  output logic                   flush_hit
);

  logic                   valid_r;
  logic [DATA_WIDTH-1:0]  data_r;
  logic [THREAD_BITS-1:0] thread_r;
  logic                   flush_hit_s;

  // Entry storage: load takes precedence over clear; data holds when cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r  <= 1'b0;
      data_r   <= '0;
      thread_r <= '0;
    end else if (load) begin
      valid_r  <= 1'b1;
      data_r   <= load_data;
      thread_r <= load_thread;
    end else if (clear) begin
      valid_r  <= 1'b0;
    end else begin
      valid_r  <= valid_r;
    end
  end

  // Flush match on the stored entry; flush_all selects every thread.
  always_comb begin
    flush_hit_s = 1'b0;
    if (valid_r && (flush_all || (flush_en && (thread_r == flush_thread)))) begin
      flush_hit_s = 1'b1;
    end else begin
      flush_hit_s = 1'b0;
    end
  end

  assign valid     = valid_r;
  assign data      = data_r;
  assign thread    = thread_r;
  assign flush_hit = flush_hit_s;

endmodule

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
// Two-entry skid-buffered pipeline stage with per-thread and global flush.
// The head entry drives out_*; the skid entry catches a beat accepted while
// the head is stalled, so in_ready can be a plain register (NOT skid valid).
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   in_valid/in_ready        : upstream handshake (in_ready is registered)
//   in_data/in_thread        : upstream payload and thread id
//   out_valid/out_ready      : downstream handshake
//   out_data/out_thread      : head payload and thread id
//   flush_en/flush_thread    : drop all entries of one thread
//   flush_all                : drop every entry (wins over flush_en)
//   occupancy                : registered count of valid entries (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int THREAD_BITS = THREAD_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [THREAD_BITS-1:0] in_thread,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [THREAD_BITS-1:0] out_thread,
  input  logic                   flush_en,
  input  logic [THREAD_BITS-1:0] flush_thread,
  input  logic                   flush_all,
  output logic [1:0]             occupancy
);

  logic                   in_ready_r;
  logic [1:0]             occupancy_r;

  logic                   head_valid_s;
  logic [DATA_WIDTH-1:0]  head_data_s;
  logic [THREAD_BITS-1:0] head_thread_s;
  logic                   head_hit_s;
  logic                   skid_valid_s;
  logic [DATA_WIDTH-1:0]  skid_data_s;
  logic [THREAD_BITS-1:0] skid_thread_s;
  logic                   skid_hit_s;

  logic                   accept_s;
  logic                   complete_s;
  logic                   beat_kill_s;
  logic                   head_keep_s;
  logic                   skid_keep_s;
  logic                   beat_keep_s;

  head_src_t              head_src_s;
  skid_src_t              skid_src_s;
  logic                   head_load_s;
  logic                   head_clear_s;
  logic [DATA_WIDTH-1:0]  head_load_data_s;
  logic [THREAD_BITS-1:0] head_load_thread_s;
  logic                   skid_load_s;
  logic                   skid_clear_s;
  logic                   head_valid_next_s;
  logic                   skid_valid_next_s;

  assign accept_s   = in_valid & in_ready_r;
  assign complete_s = head_valid_s & out_ready;

  // Flush selection of the incoming beat; a discarded beat is still accepted.
  always_comb begin
    beat_kill_s = 1'b0;
    if (flush_all || (flush_en && (in_thread == flush_thread))) begin
      beat_kill_s = 1'b1;
    end else begin
      beat_kill_s = 1'b0;
    end
  end

  // Survivors of this edge, oldest first: held head, skid, accepted beat.
  // A completed head has been delivered, so the flush never applies to it.
  // A beat is only accepted while the skid is empty, so at most two survive.
  assign head_keep_s = head_valid_s & ~complete_s & ~head_hit_s;
  assign skid_keep_s = skid_valid_s & ~skid_hit_s;
  assign beat_keep_s = accept_s & ~beat_kill_s;

  // Source selection: the oldest survivor goes to the head, the next to the skid.
  always_comb begin
    head_src_s = HEAD_EMPTY;
    skid_src_s = SKID_EMPTY;
    if (head_keep_s) begin
      head_src_s = HEAD_HOLD;
    end else if (skid_keep_s) begin
      head_src_s = HEAD_FROM_SKID;
    end else if (beat_keep_s) begin
      head_src_s = HEAD_FROM_IN;
    end else begin
      head_src_s = HEAD_EMPTY;
    end
    if (head_keep_s && skid_keep_s) begin
      skid_src_s = SKID_HOLD;
    end else if ((head_keep_s || skid_keep_s) && beat_keep_s) begin
      skid_src_s = SKID_FROM_IN;
    end else begin
      skid_src_s = SKID_EMPTY;
    end
  end

  // Decode the head source into load/clear controls and the load mux.
  always_comb begin
    head_load_s        = 1'b0;
    head_clear_s       = 1'b0;
    head_load_data_s   = in_data;
    head_load_thread_s = in_thread;
    head_valid_next_s  = 1'b0;
    case (head_src_s)
      HEAD_HOLD: begin
        head_valid_next_s = 1'b1;
      end
      HEAD_FROM_SKID: begin
        head_load_s        = 1'b1;
        head_load_data_s   = skid_data_s;
        head_load_thread_s = skid_thread_s;
        head_valid_next_s  = 1'b1;
      end
      HEAD_FROM_IN: begin
        head_load_s       = 1'b1;
        head_valid_next_s = 1'b1;
      end
      HEAD_EMPTY: begin
        head_clear_s = 1'b1;
      end
      default: begin
        head_clear_s = 1'b1;
      end
    endcase
  end

  // Decode the skid source into load/clear controls.
  always_comb begin
    skid_load_s       = 1'b0;
    skid_clear_s      = 1'b0;
    skid_valid_next_s = 1'b0;
    case (skid_src_s)
      SKID_HOLD: begin
        skid_valid_next_s = 1'b1;
      end
      SKID_FROM_IN: begin
        skid_load_s       = 1'b1;
        skid_valid_next_s = 1'b1;
      end
      SKID_EMPTY: begin
        skid_clear_s = 1'b1;
      end
      default: begin
        skid_clear_s = 1'b1;
      end
    endcase
  end

  pipe_entry_reg #(
    .DATA_WIDTH  (DATA_WIDTH),
    .THREAD_BITS (THREAD_BITS)
  ) u_head (
    .clk          (clk),
    .reset        (reset),
    .load         (head_load_s),
    .load_data    (head_load_data_s),
    .load_thread  (head_load_thread_s),
    .clear        (head_clear_s),
    .flush_en     (flush_en),
    .flush_thread (flush_thread),
    .flush_all    (flush_all),
    .valid        (head_valid_s),
    .data         (head_data_s),
    .thread       (head_thread_s),
    .flush_hit    (head_hit_s)
  );

  pipe_entry_reg #(
    .DATA_WIDTH  (DATA_WIDTH),
    .THREAD_BITS (THREAD_BITS)
  ) u_skid (
    .clk          (clk),
    .reset        (reset),
    .load         (skid_load_s),
    .load_data    (in_data),
    .load_thread  (in_thread),
    .clear        (skid_clear_s),
    .flush_en     (flush_en),
    .flush_thread (flush_thread),
    .flush_all    (flush_all),
    .valid        (skid_valid_s),
    .data         (skid_data_s),
    .thread       (skid_thread_s),
    .flush_hit    (skid_hit_s)
  );

  // Registered status: in_ready mirrors the next skid-empty state.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_r  <= 1'b1;
      occupancy_r <= 2'd0;
    end else begin
      in_ready_r  <= ~skid_valid_next_s;
      occupancy_r <= count_valid(head_valid_next_s, skid_valid_next_s);
    end
  end

  assign in_ready   = in_ready_r;
  assign occupancy  = occupancy_r;
  assign out_valid  = head_valid_s;
  assign out_data   = head_data_s;
  assign out_thread = head_thread_s;

endmodule
